// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. One issue register drives the ALU for a single cycle; the ALU
// outputs are captured into a per-requester response slot that is held until
// its requester consumes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  input  logic [3:0]       i_req0_ctrl,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [3:0]       i_req1_ctrl,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_req1_ready,
  output logic             o_rsp0_valid,
  output logic [WIDTH-1:0] o_rsp0_result,
  output logic [2:0]       o_rsp0_flags,
  output logic             o_rsp0_illegal,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  output logic [WIDTH-1:0] o_rsp1_result,
  output logic [2:0]       o_rsp1_flags,
  output logic             o_rsp1_illegal,
  input  logic             i_rsp1_ready,
  output logic [3:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  input  logic             i_alu_neg,
  input  logic             i_alu_negU
);

  // Codes outside 0000-0111, 1101, 1110 are still executed but flagged.
  function automatic logic ctrl_illegal(input logic [3:0] c);
    return !((c[3] == 1'b0) || (c == 4'b1101) || (c == 4'b1110));
  endfunction

  // Issue register and round-robin pointer
  logic             iss_valid_q, iss_valid_d;
  logic             iss_owner_q, iss_owner_d;
  logic [3:0]       iss_ctrl_q,  iss_ctrl_d;
  logic [WIDTH-1:0] iss_a_q,     iss_a_d;
  logic [WIDTH-1:0] iss_b_q,     iss_b_d;
  logic             last_q,      last_d;

  // Response slots, index = requester
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q [2];
  logic [WIDTH-1:0] rsp_result_d [2];
  logic [2:0]       rsp_flags_q  [2];
  logic [2:0]       rsp_flags_d  [2];
  logic [1:0]       rsp_ill_q,   rsp_ill_d;

  logic [1:0] req_valid, rsp_ready, elig, ve, ready, acc, cap;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

  // A requester is eligible when its slot will be free and its previous op is
  // not still in the issue register, so the issue register never stalls.
  assign elig[0] = (!rsp_valid_q[0] || rsp_ready[0]) && !(iss_valid_q && !iss_owner_q);
  assign elig[1] = (!rsp_valid_q[1] || rsp_ready[1]) && !(iss_valid_q &&  iss_owner_q);
  assign ve      = req_valid & elig;

  // Ready looks only at the other side's valid; last_q==1 gives req0 priority.
  assign ready[0] = elig[0] && (!ve[1] ||  last_q);
  assign ready[1] = elig[1] && (!ve[0] || !last_q);
  assign acc      = req_valid & ready;

  assign cap = {iss_valid_q & iss_owner_q, iss_valid_q & ~iss_owner_q};

  assign o_req0_ready = ready[0];
  assign o_req1_ready = ready[1];

  // Idle ALU inputs are driven to an add of zeros rather than stale operands.
  assign o_alu_ctrl = iss_valid_q ? iss_ctrl_q : 4'b0000;
  assign o_alu_a    = iss_valid_q ? iss_a_q    : '0;
  assign o_alu_b    = iss_valid_q ? iss_b_q    : '0;

  assign o_rsp0_valid   = rsp_valid_q[0];
  assign o_rsp0_result  = rsp_result_q[0];
  assign o_rsp0_flags   = rsp_flags_q[0];
  assign o_rsp0_illegal = rsp_ill_q[0];
  assign o_rsp1_valid   = rsp_valid_q[1];
  assign o_rsp1_result  = rsp_result_q[1];
  assign o_rsp1_flags   = rsp_flags_q[1];
  assign o_rsp1_illegal = rsp_ill_q[1];

  // Grant loads the issue register; without a grant it empties next cycle.
  always_comb begin
    iss_valid_d = 1'b0;
    iss_owner_d = iss_owner_q;
    iss_ctrl_d  = iss_ctrl_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    last_d      = last_q;
    if (acc[0]) begin
      iss_valid_d = 1'b1;
      iss_owner_d = 1'b0;
      iss_ctrl_d  = i_req0_ctrl;
      iss_a_d     = i_req0_a;
      iss_b_d     = i_req0_b;
      last_d      = 1'b0;
    end else if (acc[1]) begin
      iss_valid_d = 1'b1;
      iss_owner_d = 1'b1;
      iss_ctrl_d  = i_req1_ctrl;
      iss_a_d     = i_req1_a;
      iss_b_d     = i_req1_b;
      last_d      = 1'b1;
    end
  end

  // Slots capture the ALU output at the end of the issue cycle, drain on ready.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_ill_d   = rsp_ill_q;
    for (int k = 0; k < 2; k++) begin
      rsp_result_d[k] = rsp_result_q[k];
      rsp_flags_d[k]  = rsp_flags_q[k];
      if (cap[k]) begin
        rsp_valid_d[k]  = 1'b1;
        rsp_result_d[k] = i_alu_result;
        rsp_flags_d[k]  = {i_alu_zero, i_alu_neg, i_alu_negU};
        rsp_ill_d[k]    = ctrl_illegal(iss_ctrl_q);
      end else if (rsp_valid_q[k] && rsp_ready[k]) begin
        rsp_valid_d[k]  = 1'b0;
      end
    end
  end

  // State registers; reset discards any in-flight op and clears the slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iss_valid_q <= 1'b0;
      iss_owner_q <= 1'b0;
      iss_ctrl_q  <= '0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      last_q      <= 1'b1;
      rsp_valid_q <= '0;
      rsp_ill_q   <= '0;
      for (int k = 0; k < 2; k++) begin
        rsp_result_q[k] <= '0;
        rsp_flags_q[k]  <= '0;
      end
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_owner_q <= iss_owner_d;
      iss_ctrl_q  <= iss_ctrl_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ill_q   <= rsp_ill_d;
      for (int k = 0; k < 2; k++) begin
        rsp_result_q[k] <= rsp_result_d[k];
        rsp_flags_q[k]  <= rsp_flags_d[k];
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_req0_valid, i_req1_valid;
  logic [3:0]   i_req0_ctrl, i_req1_ctrl;
  logic [W-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic         o_req0_ready, o_req1_ready;
  logic         o_rsp0_valid, o_rsp1_valid;
  logic [W-1:0] o_rsp0_result, o_rsp1_result;
  logic [2:0]   o_rsp0_flags, o_rsp1_flags;
  logic         o_rsp0_illegal, o_rsp1_illegal;
  logic         i_rsp0_ready, i_rsp1_ready;
  logic [3:0]   o_alu_ctrl;
  logic [W-1:0] o_alu_a, o_alu_b;
  logic [W-1:0] alu_res;
  logic         alu_negu;

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  // Behavioural ALU; unknown codes return a recognisable pattern.
  always_comb begin
    alu_res  = '0;
    alu_negu = 1'b0;
    case (o_alu_ctrl)
      4'b0000: alu_res = o_alu_a + o_alu_b;
      4'b0001: alu_res = o_alu_a - o_alu_b;
      4'b0010: alu_res = o_alu_a & o_alu_b;
      4'b0011: alu_res = o_alu_a | o_alu_b;
      4'b0100: alu_res = o_alu_a ^ o_alu_b;
      4'b0101: alu_res = {31'd0, ($signed(o_alu_a) < $signed(o_alu_b))};
      4'b0110: begin
        alu_res  = {31'd0, (o_alu_a < o_alu_b)};
        alu_negu = (o_alu_a < o_alu_b);
      end
      4'b0111: alu_res = o_alu_a << o_alu_b[4:0];
      4'b1101: alu_res = o_alu_a >> o_alu_b[4:0];
      4'b1110: alu_res = $signed(o_alu_a) >>> o_alu_b[4:0];
      default: alu_res = 32'hBAD0_0000 ^ o_alu_a;
    endcase
  end

  alu_arbiter #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .i_req0_ctrl(i_req0_ctrl), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_ctrl(i_req1_ctrl), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
    .o_req1_ready(o_req1_ready),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp0_result(o_rsp0_result), .o_rsp0_flags(o_rsp0_flags),
    .o_rsp0_illegal(o_rsp0_illegal), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp1_valid(o_rsp1_valid), .o_rsp1_result(o_rsp1_result), .o_rsp1_flags(o_rsp1_flags),
    .o_rsp1_illegal(o_rsp1_illegal), .i_rsp1_ready(i_rsp1_ready),
    .o_alu_ctrl(o_alu_ctrl), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .i_alu_result(alu_res), .i_alu_zero(alu_res == '0), .i_alu_neg(alu_res[W-1]), .i_alu_negU(alu_negu)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_req0_valid = 0; i_req0_ctrl = 0; i_req0_a = 0; i_req0_b = 0;
    i_req1_valid = 0; i_req1_ctrl = 0; i_req1_a = 0; i_req1_b = 0;
    i_rsp0_ready = 0; i_rsp1_ready = 0;
    #12;
    n_cmp++; if (o_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp0_valid: got %0h want 0", o_rsp0_valid); end
    n_cmp++; if (o_rsp1_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp1_valid: got %0h want 0", o_rsp1_valid); end
    n_cmp++; if (o_rsp0_result !== 32'd0) begin n_err++; $display("FAIL reset_rsp0_result: got %0h want 0", o_rsp0_result); end
    n_cmp++; if (o_rsp1_result !== 32'd0) begin n_err++; $display("FAIL reset_rsp1_result: got %0h want 0", o_rsp1_result); end
    n_cmp++; if ({o_rsp0_flags, o_rsp0_illegal} !== 4'd0) begin n_err++; $display("FAIL reset_rsp0_flags: got %0h/%0h want 0/0", o_rsp0_flags, o_rsp0_illegal); end
    n_cmp++; if ({o_rsp1_flags, o_rsp1_illegal} !== 4'd0) begin n_err++; $display("FAIL reset_rsp1_flags: got %0h/%0h want 0/0", o_rsp1_flags, o_rsp1_illegal); end
    n_cmp++; if ({o_alu_ctrl, o_alu_a, o_alu_b} !== '0) begin n_err++; $display("FAIL reset_alu_idle: got %0h/%0h/%0h want 0/0/0", o_alu_ctrl, o_alu_a, o_alu_b); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_cmp++; if ({o_req0_ready, o_req1_ready} !== 2'b11) begin n_err++; $display("FAIL idle_ready: got %b want 11", {o_req0_ready, o_req1_ready}); end
  endtask

  task automatic test_single_add();
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    i_req0_valid = 1; i_req0_ctrl = 4'b0000; i_req0_a = 5; i_req0_b = 7;
    #1;
    n_cmp++; if (o_req0_ready !== 1'b1) begin n_err++; $display("FAIL add_ready0: got %0h want 1", o_req0_ready); end
    tick();
    i_req0_valid = 0;
    #1;
    n_cmp++; if ({o_alu_ctrl, o_alu_a, o_alu_b} !== {4'b0000, 32'd5, 32'd7}) begin n_err++; $display("FAIL add_alu_drive: got %0h/%0h/%0h want 0/5/7", o_alu_ctrl, o_alu_a, o_alu_b); end
    n_cmp++; if (o_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp_early: got %0h want 0", o_rsp0_valid); end
    tick();
    n_cmp++; if (o_rsp0_valid !== 1'b1) begin n_err++; $display("FAIL add_rsp_valid: got %0h want 1", o_rsp0_valid); end
    n_cmp++; if (o_rsp0_result !== 32'd12) begin n_err++; $display("FAIL add_result: got %0h want c", o_rsp0_result); end
    n_cmp++; if ({o_rsp0_flags, o_rsp0_illegal} !== 4'b0000) begin n_err++; $display("FAIL add_flags: got %0h/%0h want 0/0", o_rsp0_flags, o_rsp0_illegal); end
    n_cmp++; if (o_rsp1_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp1_idle: got %0h want 0", o_rsp1_valid); end
    n_cmp++; if (o_alu_a !== 32'd0) begin n_err++; $display("FAIL add_alu_back_idle: got %0h want 0", o_alu_a); end
    tick();
    n_cmp++; if (o_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp_drain: got %0h want 0", o_rsp0_valid); end
  endtask

  task automatic test_contention();
    i_rst_n = 0; #2; i_rst_n = 1;
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    i_req0_valid = 1; i_req0_ctrl = 4'b0001; i_req0_a = 3; i_req0_b = 5;
    i_req1_valid = 1; i_req1_ctrl = 4'b0110; i_req1_a = 3; i_req1_b = 5;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (o_req0_ready !== (i % 2 == 0)) begin n_err++; $display("FAIL cont_ready0[%0d]: got %0h want %0h", i, o_req0_ready, (i % 2 == 0)); end
      n_cmp++; if (o_req1_ready !== (i % 2 == 1)) begin n_err++; $display("FAIL cont_ready1[%0d]: got %0h want %0h", i, o_req1_ready, (i % 2 == 1)); end
      tick();
      n_cmp++; if (o_rsp0_valid !== (i % 2 == 1)) begin n_err++; $display("FAIL cont_rsp0_valid[%0d]: got %0h want %0h", i, o_rsp0_valid, (i % 2 == 1)); end
      n_cmp++; if (o_rsp1_valid !== ((i % 2 == 0) && (i >= 2))) begin n_err++; $display("FAIL cont_rsp1_valid[%0d]: got %0h", i, o_rsp1_valid); end
      if (i % 2 == 1) begin
        n_cmp++; if ({o_rsp0_result, o_rsp0_flags} !== {32'hFFFF_FFFE, 3'b010}) begin n_err++; $display("FAIL cont_sub[%0d]: got %0h/%0h want fffffffe/2", i, o_rsp0_result, o_rsp0_flags); end
      end
      if ((i % 2 == 0) && (i >= 2)) begin
        n_cmp++; if ({o_rsp1_result, o_rsp1_flags} !== {32'd1, 3'b001}) begin n_err++; $display("FAIL cont_sltu[%0d]: got %0h/%0h want 1/1", i, o_rsp1_result, o_rsp1_flags); end
      end
    end
    i_req0_valid = 0; i_req1_valid = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    i_rsp0_ready = 0; i_rsp1_ready = 1;
    i_req0_valid = 1; i_req0_ctrl = 4'b0000; i_req0_a = 10; i_req0_b = 20;
    #1;
    n_cmp++; if (o_req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready0: got %0h want 1", o_req0_ready); end
    tick();
    i_req0_a = 1; i_req0_b = 1;
    i_req1_valid = 1; i_req1_ctrl = 4'b0000; i_req1_a = 100; i_req1_b = 1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (o_req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready0[%0d]: got %0h want 0", k, o_req0_ready); end
      n_cmp++; if (o_req1_ready !== (k % 2 == 1)) begin n_err++; $display("FAIL bp_ready1[%0d]: got %0h want %0h", k, o_req1_ready, (k % 2 == 1)); end
      if (k >= 2) begin
        n_cmp++; if ({o_rsp0_valid, o_rsp0_result} !== {1'b1, 32'd30}) begin n_err++; $display("FAIL bp_slot0_hold[%0d]: got %0h/%0h want 1/1e", k, o_rsp0_valid, o_rsp0_result); end
      end
      tick();
      n_cmp++; if (o_rsp1_valid !== ((k % 2 == 0) && (k >= 2))) begin n_err++; $display("FAIL bp_rsp1_valid[%0d]: got %0h", k, o_rsp1_valid); end
      if ((k % 2 == 0) && (k >= 2)) begin
        n_cmp++; if (o_rsp1_result !== 32'd101) begin n_err++; $display("FAIL bp_rsp1_result[%0d]: got %0h want 65", k, o_rsp1_result); end
      end
    end
    i_req1_valid = 0; i_rsp0_ready = 1;
    #1;
    n_cmp++; if (o_req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready0: got %0h want 1", o_req0_ready); end
    tick();
    i_req0_valid = 0;
    n_cmp++; if (o_rsp0_valid !== 1'b0) begin n_err++; $display("FAIL bp_slot0_drain: got %0h want 0", o_rsp0_valid); end
    tick();
    n_cmp++; if ({o_rsp0_valid, o_rsp0_result} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL bp_after_release: got %0h/%0h want 1/2", o_rsp0_valid, o_rsp0_result); end
    tick();
  endtask

  task automatic test_illegal();
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    i_req1_valid = 1; i_req1_ctrl = 4'b1111; i_req1_a = 7; i_req1_b = 9;
    #1;
    n_cmp++; if (o_req1_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready1: got %0h want 1", o_req1_ready); end
    tick(); i_req1_valid = 0; tick();
    n_cmp++; if ({o_rsp1_valid, o_rsp1_illegal} !== 2'b11) begin n_err++; $display("FAIL ill_1111_flag: got %0h/%0h want 1/1", o_rsp1_valid, o_rsp1_illegal); end
    n_cmp++; if ({o_rsp1_result, o_rsp1_flags} !== {32'hBAD0_0007, 3'b010}) begin n_err++; $display("FAIL ill_1111_result: got %0h/%0h want bad00007/2", o_rsp1_result, o_rsp1_flags); end
    i_req1_valid = 1; i_req1_ctrl = 4'b1101; i_req1_a = 32'h80; i_req1_b = 4;
    tick(); i_req1_valid = 0; tick();
    n_cmp++; if ({o_rsp1_valid, o_rsp1_illegal, o_rsp1_flags, o_rsp1_result} !== {2'b10, 3'b000, 32'd8}) begin n_err++; $display("FAIL ill_1101_legal: got %0h/%0h/%0h/%0h want 1/0/0/8", o_rsp1_valid, o_rsp1_illegal, o_rsp1_flags, o_rsp1_result); end
    i_req0_valid = 1; i_req0_ctrl = 4'b1000; i_req0_a = 5; i_req0_b = 0;
    tick(); i_req0_valid = 0; tick();
    n_cmp++; if ({o_rsp0_valid, o_rsp0_illegal, o_rsp0_result} !== {2'b11, 32'hBAD0_0005}) begin n_err++; $display("FAIL ill_1000: got %0h/%0h/%0h want 1/1/bad00005", o_rsp0_valid, o_rsp0_illegal, o_rsp0_result); end
    i_req0_valid = 1; i_req0_ctrl = 4'b1110; i_req0_a = 32'h8000_0000; i_req0_b = 4;
    tick(); i_req0_valid = 0; tick();
    n_cmp++; if ({o_rsp0_valid, o_rsp0_illegal, o_rsp0_flags, o_rsp0_result} !== {2'b10, 3'b010, 32'hF800_0000}) begin n_err++; $display("FAIL ill_1110_legal: got %0h/%0h/%0h/%0h want 1/0/2/f8000000", o_rsp0_valid, o_rsp0_illegal, o_rsp0_flags, o_rsp0_result); end
    tick();
  endtask

  task automatic test_reset_midflight();
    i_rsp0_ready = 1; i_rsp1_ready = 1;
    i_req0_valid = 1; i_req0_ctrl = 4'b0000; i_req0_a = 1; i_req0_b = 2;
    #1;
    tick();
    i_req0_valid = 0;
    i_rst_n = 0;
    #1;
    n_cmp++; if ({o_rsp0_valid, o_rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL mid_valids: got %b want 00", {o_rsp0_valid, o_rsp1_valid}); end
    n_cmp++; if ({o_alu_ctrl, o_alu_a, o_alu_b} !== '0) begin n_err++; $display("FAIL mid_alu_idle: got %0h/%0h/%0h want 0/0/0", o_alu_ctrl, o_alu_a, o_alu_b); end
    tick();
    i_rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if ({o_rsp0_valid, o_rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL mid_no_rsp[%0d]: got %b want 00", k, {o_rsp0_valid, o_rsp1_valid}); end
    end
    i_req0_valid = 1; i_req0_ctrl = 4'b0000; i_req0_a = 11; i_req0_b = 0;
    i_req1_valid = 1; i_req1_ctrl = 4'b0000; i_req1_a = 22; i_req1_b = 0;
    #1;
    n_cmp++; if ({o_req0_ready, o_req1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_first_grant: got %b want 10", {o_req0_ready, o_req1_ready}); end
    tick();
    i_req0_valid = 0; i_req1_valid = 0;
    n_cmp++; if (o_alu_a !== 32'd11) begin n_err++; $display("FAIL mid_alu_owner: got %0h want b", o_alu_a); end
    tick();
    n_cmp++; if ({o_rsp0_valid, o_rsp0_result, o_rsp1_valid} !== {1'b1, 32'd11, 1'b0}) begin n_err++; $display("FAIL mid_rsp: got %0h/%0h/%0h want 1/b/0", o_rsp0_valid, o_rsp0_result, o_rsp1_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av [4];
    logic [W-1:0] bv [4];
    logic [W-1:0] ev [4];
    int idx;
    int outn;
    av = '{32'd3, 32'd5, 32'd7, 32'd9};
    bv = '{32'd4, 32'd6, 32'd8, 32'd10};
    ev = '{32'd7, 32'd11, 32'd15, 32'd19};
    idx = 0; outn = 0;
    i_rsp0_ready = 1; i_req1_valid = 0; i_req0_ctrl = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      if (idx < 4) begin
        i_req0_valid = 1; i_req0_a = av[idx]; i_req0_b = bv[idx];
      end else begin
        i_req0_valid = 0;
      end
      #1;
      if (k < 8) begin
        n_cmp++; if (o_req0_ready !== (k % 2 == 0)) begin n_err++; $display("FAIL b2b_ready0[%0d]: got %0h want %0h", k, o_req0_ready, (k % 2 == 0)); end
      end
      if (i_req0_valid && o_req0_ready) idx++;
      tick();
      if (o_rsp0_valid) begin
        if (outn < 4) begin
          n_cmp++; if (o_rsp0_result !== ev[outn]) begin n_err++; $display("FAIL b2b_result[%0d]: got %0h want %0h", outn, o_rsp0_result, ev[outn]); end
        end
        outn++;
      end
    end
    n_cmp++; if (idx !== 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", idx); end
    n_cmp++; if (outn !== 4) begin n_err++; $display("FAIL b2b_deliveries: got %0d want 4", outn); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_midflight();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (req0 = execute stage, req1 = branch/address unit) using a round-robin grant and a valid/ready handshake on each side. Each accepted operation is held in one issue register that drives the ALU for exactly one cycle. The ALU outputs are then captured into a per-requester response slot, held until that requester accepts them. The block sits between the requesters and the ALU and owns the ALU's `i_ctrl`/`i_1`/`i_2` inputs.

## Interface
- `WIDTH`, 32, operand/result width; must match the ALU.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_reqK_valid`  in  1  (K=0,1) request K presents an operation.
- `i_reqK_ctrl`  in  4  ALU operation code for request K.
- `i_reqK_a`, `i_reqK_b`  in  WIDTH  operands for request K.
- `o_reqK_ready`  out  1  request K is accepted this cycle when valid and ready are both high.
- `o_rspK_valid`  out  1  response slot K holds a result.
- `o_rspK_result`  out  WIDTH  captured ALU result.
- `o_rspK_flags`  out  3  captured {zero, neg, negU}.
- `o_rspK_illegal`  out  1  the ctrl code was not in the legal set.
- `i_rspK_ready`  in  1  requester K consumes the slot when valid and ready are both high.
- `o_alu_ctrl`  out  4  drives the ALU control input.
- `o_alu_a`, `o_alu_b`  out  WIDTH  drive the ALU operand inputs.
- `i_alu_result`  in  WIDTH  ALU result.
- `i_alu_zero`, `i_alu_neg`, `i_alu_negU`  in  1  ALU flags.

## Operation
**State**
- Issue register: `iss_valid`, `iss_owner`, `iss_ctrl`, `iss_a`, `iss_b`.
- Two response slots.
- Round-robin pointer `last` (the requester most recently granted).

**Eligibility**
- `elig_K` = (`!o_rspK_valid` || `i_rspK_ready`) && !(`iss_valid` && `iss_owner`==K).
- Consequence: the issue register never stalls, because its target slot is always free when it executes.

**Arbitration**
- Only one request can be granted per cycle.
- If exactly one requester is valid and eligible, it wins.
- If both are valid and eligible, the winner is the requester ≠ `last`.
- `o_reqK_ready` = `elig_K` && (K is the winner, or the other requester is not valid-and-eligible).
- Ready may depend combinationally on the other requester's valid. Ready never depends on the requester's own valid.
- On acceptance of K: load ctrl/a/b into the issue register, set `iss_valid`=1, set `iss_owner`=K, set `last`=K.
- With no acceptance, `iss_valid` is cleared next cycle.

**Execute**
- While `iss_valid`=1, `o_alu_*` follow the issue register.
- When `iss_valid`=0, `o_alu_ctrl`=4'b0000 (add) and `o_alu_a`=`o_alu_b`=0, so the ALU input never floats to x.
- At the end of an `iss_valid` cycle, slot[`iss_owner`] captures the result and flags and sets its valid.
- Legal ctrl set: 0000–0111, 1101, 1110. Any other code is still executed and returned with `illegal`=1; the result is passed through as returned by the ALU.

**Response slots**
- A slot clears when valid && `i_rspK_ready`.
- Capture into a slot and drain of the same slot cannot happen in the same cycle; the eligibility rule guarantees this.
- Capture into slot A and drain of slot B may happen in the same cycle.

**Arithmetic**
- No arithmetic in this block. Data passes through unmodified; the flags are taken from the ALU without reinterpretation.

## Timing
**Reset** (async assert, synchronous release on the first edge after `i_rst_n` rises):
- `iss_valid`=0; `o_rspK_valid`=0.
- `o_rspK_result`=0, `o_rspK_flags`=0, `o_rspK_illegal`=0.
- `last`=1, so req0 has priority first.
- `o_alu_*` = idle values.
- An operation in flight at reset is discarded; no response is produced.

**Latency and throughput**
- Accept at edge t → ALU driven during cycle t+1 → `o_rspK_valid`=1 from t+2.
- Two requesters alternating: one accept per cycle sustained.
- A single requester with an always-ready response: one accept every 2 cycles (blocked while its own op is in the issue register).
- A requester whose response is not consumed is blocked; the other requester proceeds unaffected.

**Handshake rules**
- A requester holds valid/ctrl/a/b stable until it is accepted.
- A response slot holds result/flags stable while valid && !ready.

## Test plan
- **Single add:** req0 ctrl=0000, a=5, b=7, rsp0 ready=1 → accepted at t; `o_alu_*`=0000/5/7 in t+1; at t+2 rsp0 valid, result=12, flags=000, illegal=0; req1 side idle.
- **Contention:** both valid every cycle from reset; req0 sub 3−5, req1 sltu 3<5; both rsp ready=1 → grants req0, req1, req0, … alternating, one per cycle; rsp0 result=0xFFFFFFFE, flags=010 (neg=1 since signed result <0; zero=0; negU bit per ALU semantics); rsp1 result=1, negU=1.
- **Backpressure:** rsp0 ready=0 with slot 0 full; req0 and req1 valid → `o_req0_ready`=0 until rsp0 ready=1; req1 served every 2 cycles; slot 0 result unchanged throughout.
- **Illegal code:** req1 ctrl=1111 → response arrives at t+2 with illegal=1; subsequent legal ops unaffected.
- **Reset mid-flight:** assert `i_rst_n`=0 in the cycle after an accept → all valids 0 immediately; no response after release; first contended grant after release goes to req0.
- **Same-requester back-to-back:** req0 valid continuously, rsp0 ready=1 → `o_req0_ready` toggles 1,0,1,0; each result is delivered exactly once, in order.
